// File: rtl/playback_scheduler.sv
// rtl/playback_scheduler.sv - auto-mode note sequencer driving the shared playback datapath
module playback_scheduler #(
    parameter int SONGS      = 8,
    parameter int GAP_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  song_sel,
    input  logic        btn_play,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        loop,
    input  logic [31:0] track,
    input  logic        snd_done,
    output logic [2:0]  song_idx,
    output logic [31:0] note_idx,
    output logic        snd_en,
    output logic        snd_start,
    output logic        playing,
    output logic        paused,
    output logic        song_end
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;
    localparam logic [2:0] PAUSE = 3'd5;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    SONG_LAST = 3'(SONGS - 1);

    logic [2:0]    state, state_nx;
    logic [2:0]    song_nx;
    logic [31:0]   note_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          end_nx;
    logic [2:0]    song_inc, song_dec;
    logic          skip_nx_state;

    assign song_inc = (song_idx == SONG_LAST) ? 3'd0 : song_idx + 3'd1;
    assign song_dec = (song_idx == 3'd0) ? SONG_LAST : song_idx - 3'd1;

    // Song skips keep a paused player paused; otherwise playback restarts at FETCH.
    assign skip_nx_state = (state == PAUSE);

    always_comb begin
        state_nx = state;
        song_nx  = song_idx;
        note_nx  = note_idx;
        gap_nx   = gap_cnt;
        end_nx   = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            song_nx  = song_sel;
            note_nx  = 32'd0;
            gap_nx   = '0;
        end else if (state == IDLE) begin
            song_nx = song_sel;
            note_nx = 32'd0;
            if (btn_play)
                state_nx = FETCH;
        end else if (btn_play) begin
            state_nx = (state == PAUSE) ? FETCH : PAUSE;
        end else if (btn_next) begin
            song_nx  = song_inc;
            note_nx  = 32'd0;
            state_nx = skip_nx_state ? PAUSE : FETCH;
        end else if (btn_prev) begin
            if (note_idx == 32'd0)
                song_nx = song_dec;
            note_nx  = 32'd0;
            state_nx = skip_nx_state ? PAUSE : FETCH;
        end else begin
            case (state)
                FETCH: state_nx = START;
                START: state_nx = WAIT;
                WAIT: begin
                    if (snd_done) begin
                        state_nx = GAP;
                        gap_nx   = '0;
                        if (note_idx >= track) begin
                            end_nx  = 1'b1;
                            note_nx = 32'd0;
                            if (!loop)
                                song_nx = song_inc;
                        end else begin
                            note_nx = note_idx + 32'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state_nx = FETCH;
                    else
                        gap_nx = gap_cnt + GW'(1);
                end
                PAUSE:   state_nx = PAUSE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            song_idx  <= 3'd0;
            note_idx  <= 32'd0;
            gap_cnt   <= '0;
            snd_en    <= 1'b0;
            snd_start <= 1'b0;
            playing   <= 1'b0;
            paused    <= 1'b0;
            song_end  <= 1'b0;
        end else begin
            state     <= state_nx;
            song_idx  <= song_nx;
            note_idx  <= note_nx;
            gap_cnt   <= gap_nx;
            snd_en    <= (state_nx == START) || (state_nx == WAIT);
            snd_start <= (state_nx == START);
            playing   <= (state_nx == FETCH) || (state_nx == START) ||
                         (state_nx == WAIT)  || (state_nx == GAP);
            paused    <= (state_nx == PAUSE);
            song_end  <= end_nx;
        end
    end

endmodule

// File: tb/tb_playback_scheduler.sv
// tb/tb_playback_scheduler.sv - directed self-checking bench for playback_scheduler
module tb_playback_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  song_sel;
    logic        btn_play;
    logic        btn_next;
    logic        btn_prev;
    logic        loop;
    logic [31:0] track;
    logic        snd_done;
    logic [2:0]  song_idx;
    logic [31:0] note_idx;
    logic        snd_en;
    logic        snd_start;
    logic        playing;
    logic        paused;
    logic        song_end;

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    logic model_on  = 1'b1;
    int   eng_cnt   = 0;
    int   checks    = 0;
    int   errors    = 0;

    assign snd_done = auto_done | man_done;

    playback_scheduler #(.SONGS(8), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .song_sel  (song_sel),
        .btn_play  (btn_play),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .loop      (loop),
        .track     (track),
        .snd_done  (snd_done),
        .song_idx  (song_idx),
        .note_idx  (note_idx),
        .snd_en    (snd_en),
        .snd_start (snd_start),
        .playing   (playing),
        .paused    (paused),
        .song_end  (song_end)
    );

    always #5 clk = ~clk;

    // Sound engine: snd_done ten cycles after each snd_start.
    initial begin
        forever begin
            @(negedge clk);
            auto_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0 && model_on)
                    auto_done = 1'b1;
            end
            if (snd_start)
                eng_cnt = 10;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_play();
        btn_play = 1'b1;
        @(negedge clk);
        btn_play = 1'b0;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
    endtask

    task automatic press_prev();
        btn_prev = 1'b1;
        @(negedge clk);
        btn_prev = 1'b0;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    task automatic wait_start(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (snd_start !== 1'b1 && n < maxc);
        if (snd_start !== 1'b1)
            check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic restart(input logic [2:0] sel);
        en = 1'b0;
        cyc(1);
        song_sel = sel;
        en = 1'b1;
        cyc(1);
        press_play();
    endtask

    task automatic run_to_end(input logic lp, output int starts, output logic seen);
        int n;
        loop = lp;
        track = 32'd2;
        restart(3'd7);
        starts = 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (snd_start === 1'b1)
                starts++;
            if (song_end === 1'b1)
                seen = 1'b1;
        end
    endtask

    initial begin
        int   n;
        int   starts;
        logic seen;
        rst = 1'b1; en = 1'b0; song_sel = 3'd0; btn_play = 1'b0; btn_next = 1'b0;
        btn_prev = 1'b0; loop = 1'b0; track = 32'd100;

        // Reset state
        @(negedge clk);
        check("rst_song", {29'd0, song_idx}, 32'd0);
        check("rst_note", note_idx, 32'd0);
        check("rst_flags", {27'd0, snd_en, snd_start, playing, paused, song_end}, 32'd0);

        // Start song 5, note cadence of 16 cycles
        rst = 1'b0; en = 1'b1; song_sel = 3'd5;
        cyc(2);
        check("idle_song", {29'd0, song_idx}, 32'd5);
        press_play();
        check("fetch_start", {31'd0, snd_start}, 32'd0);
        check("fetch_play", {31'd0, playing}, 32'd1);
        cyc(1);
        check("start_pulse", {31'd0, snd_start}, 32'd1);
        check("start_en", {31'd0, snd_en}, 32'd1);
        check("start_song", {29'd0, song_idx}, 32'd5);
        check("start_note", note_idx, 32'd0);
        wait_start(40, n);
        check("period1", n, 32'd16);
        check("note1", note_idx, 32'd1);
        wait_start(40, n);
        check("period2", n, 32'd16);
        check("note2", note_idx, 32'd2);

        // End of song 7: advance wraps to 0, loop holds 7
        run_to_end(1'b0, starts, seen);
        check("end_seen", {31'd0, seen}, 32'd1);
        check("end_starts", starts, 32'd3);
        check("end_wrap_song", {29'd0, song_idx}, 32'd0);
        check("end_wrap_note", note_idx, 32'd0);
        run_to_end(1'b1, starts, seen);
        check("loop_seen", {31'd0, seen}, 32'd1);
        check("loop_song", {29'd0, song_idx}, 32'd7);

        // Pause during WAIT, ignored snd_done, resume restarts same note
        loop = 1'b0; track = 32'd100;
        restart(3'd3);
        wait_start(20, n);
        cyc(3);
        press_play();
        check("pause_flag", {31'd0, paused}, 32'd1);
        check("pause_en", {31'd0, snd_en}, 32'd0);
        check("pause_play", {31'd0, playing}, 32'd0);
        pulse_done();
        cyc(12);
        check("pause_hold", {31'd0, paused}, 32'd1);
        check("pause_note", note_idx, 32'd0);
        check("pause_end", {31'd0, song_end}, 32'd0);
        press_play();
        check("resume_fetch", {31'd0, snd_start}, 32'd0);
        cyc(1);
        check("resume_start", {31'd0, snd_start}, 32'd1);
        check("resume_note", note_idx, 32'd0);
        check("resume_song", {29'd0, song_idx}, 32'd3);

        // btn_prev: restart note, then previous songs with wrap
        restart(3'd2);
        n = 0;
        while (!(snd_start === 1'b1 && note_idx == 32'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("prev_setup_note", note_idx, 32'd3);
        press_prev();
        check("prev1_note", note_idx, 32'd0);
        check("prev1_song", {29'd0, song_idx}, 32'd2);
        press_prev();
        check("prev2_song", {29'd0, song_idx}, 32'd1);
        cyc(1);
        check("prev2_start", {31'd0, snd_start}, 32'd1);
        model_on = 1'b0;
        press_prev();
        check("prev3_song", {29'd0, song_idx}, 32'd0);
        press_prev();
        check("prev4_wrap", {29'd0, song_idx}, 32'd7);

        // btn_next beats snd_done on the last note; btn_next while paused
        track = 32'd0;
        wait_start(5, n);
        cyc(2);
        btn_next = 1'b1; man_done = 1'b1;
        @(negedge clk);
        btn_next = 1'b0; man_done = 1'b0;
        check("next_song", {29'd0, song_idx}, 32'd0);
        check("next_note", note_idx, 32'd0);
        check("next_no_end", {31'd0, song_end}, 32'd0);
        cyc(1);
        check("next_start", {31'd0, snd_start}, 32'd1);
        cyc(1);
        press_play();
        press_next();
        check("pnext_paused", {31'd0, paused}, 32'd1);
        check("pnext_song", {29'd0, song_idx}, 32'd1);
        cyc(3);
        check("pnext_hold", {31'd0, paused}, 32'd1);
        check("pnext_nostart", {31'd0, snd_start}, 32'd0);

        // Last note completes, then en drops during GAP
        press_play();
        wait_start(5, n);
        cyc(2);
        pulse_done();
        check("done_end", {31'd0, song_end}, 32'd1);
        check("done_song", {29'd0, song_idx}, 32'd2);
        cyc(1);
        check("end_one_cycle", {31'd0, song_end}, 32'd0);
        song_sel = 3'd6; en = 1'b0;
        @(negedge clk);
        check("en_idle_play", {31'd0, playing}, 32'd0);
        check("en_idle_song", {29'd0, song_idx}, 32'd6);
        song_sel = 3'd4;
        cyc(1);
        check("en_track_song", {29'd0, song_idx}, 32'd4);

        // Asynchronous reset mid-WAIT
        en = 1'b1;
        cyc(1);
        press_play();
        wait_start(5, n);
        cyc(2);
        check("pre_rst_en", {31'd0, snd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_en", {31'd0, snd_en}, 32'd0);
        check("arst_play", {31'd0, playing}, 32'd0);
        check("arst_song", {29'd0, song_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
